// File: rtl/ddr_port_arb.sv
// ddr_port_arb: two-requester arbiter in front of a single DDR command port.
// Optional feature macro: DDR_ARB_TIMEOUT_EN enables a WAIT_DONE watchdog
// (TIMEOUT_CYC cycles) that abandons a stuck transfer and sets o_timeout.
//
// Handshake: a requester holds i_rqN_wr/i_rqN_rd high to ask for service.
// The request is sampled only in IDLE. Once granted, the transfer runs to
// completion regardless of the request level. Completion is a single-cycle
// o_rqN_done pulse. On the DDR side, the strobe (o_ddr_wr/o_ddr_rd) plus
// address and data stay stable until the matching done input is sampled high.
// Any other done input is ignored.
module ddr_port_arb #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic         i_clk,
    input  logic         reset,
    input  logic         i_rq0_wr,
    input  logic         i_rq0_rd,
    input  logic [26:0]  i_rq0_addr,
    input  logic [511:0] i_rq0_wdata,
    input  logic         i_rq1_wr,
    input  logic         i_rq1_rd,
    input  logic [26:0]  i_rq1_addr,
    input  logic [511:0] i_rq1_wdata,
    output logic         o_rq0_done,
    output logic         o_rq1_done,
    output logic [511:0] o_rd_data,
    output logic         o_ddr_wr,
    output logic         o_ddr_rd,
    output logic [26:0]  o_ddr_addr,
    output logic [511:0] o_ddr_wdata,
    input  logic         i_ddr_wr_done,
    input  logic         i_ddr_rd_done,
    input  logic [511:0] i_ddr_rd_data,
    output logic [1:0]   o_gnt,
    output logic         o_timeout,
    output logic [1:0]   o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    state_t         state_q;
    logic           owner_q;     // 0 = requester 0, 1 = requester 1
    logic           op_wr_q;     // 1 = write, 0 = read
    logic [26:0]    addr_q;
    logic [511:0]   wdata_q;
    logic           last_q;      // requester served most recently
    logic [1:0]     gnt_q;
    logic           ddr_wr_q;
    logic           ddr_rd_q;
    logic [26:0]    ddr_addr_q;
    logic [511:0]   ddr_wdata_q;
    logic [511:0]   rd_data_q;
    logic           done0_q;
    logic           done1_q;

    logic           rq0_act;
    logic           rq1_act;
    logic           owner_d;
    logic           op_wr_d;
    logic [26:0]    addr_d;
    logic [511:0]   wdata_d;
    logic           done_hit;

    assign rq0_act = i_rq0_wr | i_rq0_rd;
    assign rq1_act = i_rq1_wr | i_rq1_rd;

    // Pick the next owner: on a tie the requester not served last wins;
    // within one requester a write beats a read.
    always_comb begin
        owner_d = 1'b0;
        if (rq0_act && rq1_act) begin
            owner_d = ~last_q;
        end else if (rq1_act) begin
            owner_d = 1'b1;
        end
        op_wr_d = owner_d ? i_rq1_wr    : i_rq0_wr;
        addr_d  = owner_d ? i_rq1_addr  : i_rq0_addr;
        wdata_d = owner_d ? i_rq1_wdata : i_rq0_wdata;
    end

    // A done input counts only when it matches the operation in flight.
    assign done_hit = op_wr_q ? i_ddr_wr_done : i_ddr_rd_done;

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q;
    logic          timeout_q;
`endif

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            op_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            last_q      <= 1'b1;
            gnt_q       <= 2'b00;
            ddr_wr_q    <= 1'b0;
            ddr_rd_q    <= 1'b0;
            ddr_addr_q  <= '0;
            ddr_wdata_q <= '0;
            rd_data_q   <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            // Done pulses last exactly one cycle (the RELEASE cycle).
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rq0_act || rq1_act) begin
                        owner_q <= owner_d;
                        op_wr_q <= op_wr_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        gnt_q   <= owner_d ? 2'b10 : 2'b01;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    ddr_wr_q    <= op_wr_q;
                    ddr_rd_q    <= ~op_wr_q;
                    ddr_addr_q  <= addr_q;
                    ddr_wdata_q <= wdata_q;
`ifdef DDR_ARB_TIMEOUT_EN
                    cnt_q       <= '0;
`endif
                    state_q     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_hit) begin
                        ddr_wr_q <= 1'b0;
                        ddr_rd_q <= 1'b0;
                        if (!op_wr_q) begin
                            rd_data_q <= i_ddr_rd_data;
                        end
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                        state_q <= RELEASE;
                    end
`ifdef DDR_ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        ddr_wr_q  <= 1'b0;
                        ddr_rd_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        done0_q   <= ~owner_q;
                        done1_q   <= owner_q;
                        state_q   <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    gnt_q   <= 2'b00;
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt       = gnt_q;
    assign o_ddr_wr    = ddr_wr_q;
    assign o_ddr_rd    = ddr_rd_q;
    assign o_ddr_addr  = ddr_addr_q;
    assign o_ddr_wdata = ddr_wdata_q;
    assign o_rd_data   = rd_data_q;
    assign o_rq0_done  = done0_q;
    assign o_rq1_done  = done1_q;
    assign o_dbg_state = state_q;
`ifdef DDR_ARB_TIMEOUT_EN
    assign o_timeout   = timeout_q;
`else
    assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_port_arb.sv
// Directed bench for ddr_port_arb; honours DDR_ARB_TIMEOUT_EN when defined.
module tb_ddr_port_arb;

    logic         i_clk;
    logic         reset;
    logic         i_rq0_wr, i_rq0_rd, i_rq1_wr, i_rq1_rd;
    logic [26:0]  i_rq0_addr, i_rq1_addr;
    logic [511:0] i_rq0_wdata, i_rq1_wdata;
    logic         o_rq0_done, o_rq1_done;
    logic [511:0] o_rd_data;
    logic         o_ddr_wr, o_ddr_rd;
    logic [26:0]  o_ddr_addr;
    logic [511:0] o_ddr_wdata;
    logic         i_ddr_wr_done, i_ddr_rd_done;
    logic [511:0] i_ddr_rd_data;
    logic [1:0]   o_gnt;
    logic         o_timeout;
    logic [1:0]   o_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [511:0] exp_q[$];
    logic [511:0] pat_a, pat_b, rdat, exp_rd;

    ddr_port_arb #(.TIMEOUT_CYC(16)) dut (
        .i_clk(i_clk), .reset(reset),
        .i_rq0_wr(i_rq0_wr), .i_rq0_rd(i_rq0_rd), .i_rq0_addr(i_rq0_addr), .i_rq0_wdata(i_rq0_wdata),
        .i_rq1_wr(i_rq1_wr), .i_rq1_rd(i_rq1_rd), .i_rq1_addr(i_rq1_addr), .i_rq1_wdata(i_rq1_wdata),
        .o_rq0_done(o_rq0_done), .o_rq1_done(o_rq1_done), .o_rd_data(o_rd_data),
        .o_ddr_wr(o_ddr_wr), .o_ddr_rd(o_ddr_rd), .o_ddr_addr(o_ddr_addr), .o_ddr_wdata(o_ddr_wdata),
        .i_ddr_wr_done(i_ddr_wr_done), .i_ddr_rd_done(i_ddr_rd_done), .i_ddr_rd_data(i_ddr_rd_data),
        .o_gnt(o_gnt), .o_timeout(o_timeout), .o_dbg_state(o_dbg_state)
    );

    // Clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Driver tasks
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue a read completion with random data and record it as expected.
    task automatic give_rd_done();
        rdat = {16{$urandom_range(32'hFFFF_FFFF, 0)}};
        i_ddr_rd_data = rdat;
        i_ddr_rd_done = 1'b1;
        exp_q.push_back(rdat);
    endtask

    task automatic check_rd_data(input string tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 512'd1, 512'd0);
        end else begin
            exp_rd = exp_q.pop_front();
            chk(tag, o_rd_data, exp_rd);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        pat_a = {16{32'hA5A5_0F0F}};
        pat_b = {16{32'h1234_5678}};
        i_rq0_wr = 0; i_rq0_rd = 0; i_rq1_wr = 0; i_rq1_rd = 0;
        i_rq0_addr = '0; i_rq1_addr = '0; i_rq0_wdata = '0; i_rq1_wdata = '0;
        i_ddr_wr_done = 0; i_ddr_rd_done = 0; i_ddr_rd_data = '0;
        do_reset();

        // Reset state
        chk("rst_gnt", o_gnt, 0);
        chk("rst_wr", o_ddr_wr, 0);
        chk("rst_rd", o_ddr_rd, 0);
        chk("rst_done0", o_rq0_done, 0);
        chk("rst_done1", o_rq1_done, 0);
        chk("rst_timeout", o_timeout, 0);
        chk("rst_rd_data", o_rd_data, 0);
        chk("rst_addr", o_ddr_addr, 0);
        chk("rst_wdata", o_ddr_wdata, 0);
        chk("rst_state", o_dbg_state, 0);

        // Stray done while idle must be ignored
        i_ddr_wr_done = 1; i_ddr_rd_done = 1;
        tick();
        i_ddr_wr_done = 0; i_ddr_rd_done = 0;
        chk("idle_done_gnt", o_gnt, 0);
        chk("idle_done_pulse", o_rq0_done, 0);
        chk("idle_done_state", o_dbg_state, 0);

        // rq0 write, addr 0x40, wr_done five cycles after the strobe
        i_rq0_wr = 1; i_rq0_addr = 27'h0000040; i_rq0_wdata = pat_a;
        tick();
        i_rq0_wr = 0;  // dropping the request must not abort the transfer
        chk("w_gnt", o_gnt, 2'b01);
        chk("w_state_issue", o_dbg_state, 1);
        chk("w_no_strobe_yet", o_ddr_wr, 0);
        tick();
        chk("w_strobe", o_ddr_wr, 1);
        chk("w_rd_low", o_ddr_rd, 0);
        chk("w_addr", o_ddr_addr, 27'h40);
        chk("w_wdata", o_ddr_wdata, pat_a);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) i_ddr_rd_done = 1;  // wrong done during a write
            tick();
            i_ddr_rd_done = 0;
            chk("w_hold_strobe", o_ddr_wr, 1);
            chk("w_hold_addr", o_ddr_addr, 27'h40);
            chk("w_hold_wdata", o_ddr_wdata, pat_a);
            chk("w_hold_nodone", o_rq0_done, 0);
        end
        i_ddr_wr_done = 1;
        tick();
        i_ddr_wr_done = 0;
        chk("w_strobe_drop", o_ddr_wr, 0);
        chk("w_done_pulse", o_rq0_done, 1);
        chk("w_done1_quiet", o_rq1_done, 0);
        chk("w_gnt_release", o_gnt, 2'b01);
        tick();
        chk("w_done_single", o_rq0_done, 0);
        chk("w_gnt_clear", o_gnt, 0);
        chk("w_rd_data_untouched", o_rd_data, 0);

        // Both requesters read, held: expect rq0, rq1, rq0 after a fresh reset
        do_reset();
        i_rq0_rd = 1; i_rq0_addr = 27'h0000100;
        i_rq1_rd = 1; i_rq1_addr = 27'h7FFFFC0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rr_gnt", o_gnt, (k == 1) ? 2'b10 : 2'b01);
            tick();
            chk("rr_rd_strobe", o_ddr_rd, 1);
            chk("rr_wr_low", o_ddr_wr, 0);
            chk("rr_addr", o_ddr_addr, (k == 1) ? 27'h7FFFFC0 : 27'h0000100);
            give_rd_done();
            i_ddr_wr_done = 1;  // wrong done alongside, must not matter
            tick();
            i_ddr_rd_done = 0; i_ddr_wr_done = 0;
            if (k == 2) begin
                i_rq0_rd = 0; i_rq1_rd = 0;
            end
            chk("rr_done0", o_rq0_done, (k == 1) ? 1'b0 : 1'b1);
            chk("rr_done1", o_rq1_done, (k == 1) ? 1'b1 : 1'b0);
            chk("rr_strobe_drop", o_ddr_rd, 0);
            check_rd_data("rr_rd_data");
            tick();
            chk("rr_gnt_clear", o_gnt, 0);
        end
        tick();
        chk("rr_idle_gnt", o_gnt, 0);

        // rq1 with write and read both high: write first, then read
        i_rq1_wr = 1; i_rq1_rd = 1; i_rq1_addr = 27'h0001000; i_rq1_wdata = pat_b;
        tick();
        chk("wr_first_gnt", o_gnt, 2'b10);
        tick();
        chk("wr_first_wr", o_ddr_wr, 1);
        chk("wr_first_rd", o_ddr_rd, 0);
        chk("wr_first_wdata", o_ddr_wdata, pat_b);
        i_ddr_wr_done = 1;
        tick();
        i_ddr_wr_done = 0;
        i_rq1_wr = 0;
        chk("wr_first_done", o_rq1_done, 1);
        chk("wr_first_no_overlap", {o_ddr_wr, o_ddr_rd}, 2'b00);
        tick();
        tick();
        chk("rd_second_gnt", o_gnt, 2'b10);
        tick();
        chk("rd_second_rd", o_ddr_rd, 1);
        chk("rd_second_wr", o_ddr_wr, 0);
        give_rd_done();
        tick();
        i_ddr_rd_done = 0;
        i_rq1_rd = 0;
        chk("rd_second_done", o_rq1_done, 1);
        check_rd_data("rd_second_data");
        tick();

        // Reset in WAIT_DONE abandons the transfer
        i_rq0_rd = 1; i_rq0_addr = 27'h0000080;
        tick();
        i_rq0_rd = 0;
        tick();
        tick();
        chk("mid_state_wait", o_dbg_state, 2);
        reset = 1;
        tick();
        reset = 0;
        chk("mid_rst_gnt", o_gnt, 0);
        chk("mid_rst_rd", o_ddr_rd, 0);
        chk("mid_rst_wr", o_ddr_wr, 0);
        chk("mid_rst_addr", o_ddr_addr, 0);
        chk("mid_rst_rd_data", o_rd_data, 0);
        chk("mid_rst_done0", o_rq0_done, 0);
        i_ddr_rd_done = 1;  // late done after the abort must be ignored
        tick();
        i_ddr_rd_done = 0;
        chk("mid_rst_no_done", o_rq0_done, 0);
        chk("mid_rst_idle", o_dbg_state, 0);

        // Watchdog behaviour
        i_rq0_rd = 1;
        tick();
        i_rq0_rd = 0;
        tick();
        chk("wd_strobe", o_ddr_rd, 1);
`ifdef DDR_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("wd_hold", o_ddr_rd, 1);
            chk("wd_no_flag", o_timeout, 0);
        end
        tick();
        chk("wd_drop", o_ddr_rd, 0);
        chk("wd_flag", o_timeout, 1);
        chk("wd_done", o_rq0_done, 1);
        chk("wd_rd_data_kept", o_rd_data, 0);
        tick();
        chk("wd_gnt_clear", o_gnt, 0);
        chk("wd_flag_sticky", o_timeout, 1);
`else
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("wd_wait_forever", o_ddr_rd, 1);
            chk("wd_flag_zero", o_timeout, 0);
        end
        give_rd_done();
        tick();
        i_ddr_rd_done = 0;
        chk("wd_late_done", o_rq0_done, 1);
        check_rd_data("wd_late_data");
        tick();
        chk("wd_gnt_clear", o_gnt, 0);
`endif

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
